// File: rtl/deserializador_4_bits_pkg.sv
// Shared constants for the serial-to-parallel receiver: FSM encodings,
// bit-order encodings and the default word width.
package deserializador_4_bits_pkg;

  localparam int ANCHO_DEF = 4;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_RECIBE = 1'b1;

  localparam logic DIR_MSB_FIRST = 1'b0;
  localparam logic DIR_LSB_FIRST = 1'b1;

endpackage

// File: rtl/deserializador_4_bits_if.sv
// Bus between the serial source / word consumer and the receiver.
// Serial side is strobed by ENB, no backpressure. Word side: VALID=1 means Q holds an
// unconsumed word; it is consumed on any rising edge where VALID=1 and RDY_IN=1.
interface deserializador_4_bits_if
  import deserializador_4_bits_pkg::*;
#(
  parameter int ANCHO = ANCHO_DEF
);
  logic             ENB;
  logic             S_IN;
  logic             START;
  logic             DIR;
  logic             RDY_IN;
  logic [ANCHO-1:0] Q;
  logic             VALID;
  logic             BUSY;
  logic             OVERRUN;
  logic [0:0]       state_dbg;

  modport master (
    output ENB, S_IN, START, DIR, RDY_IN,
    input  Q, VALID, BUSY, OVERRUN, state_dbg
  );

  modport slave (
    input  ENB, S_IN, START, DIR, RDY_IN,
    output Q, VALID, BUSY, OVERRUN, state_dbg
  );
endinterface

// File: rtl/deserializador_4_bits_captura_serie.sv
// Shift register with direction-controlled insertion; load_first clears it
// so the incoming bit becomes the first bit of a fresh frame.
module deserializador_4_bits_captura_serie
  import deserializador_4_bits_pkg::*;
#(
  parameter int ANCHO = ANCHO_DEF
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             shift_en,
  input  logic             load_first,
  input  logic             dir_q,
  input  logic             S_IN,
  output logic [ANCHO-1:0] word_next,
  output logic [ANCHO-1:0] word
);

  logic [ANCHO-1:0] base;

  // word_next is exposed so the completion edge can load the word including its last bit
  always_comb begin
    base      = load_first ? '0 : word;
    word_next = word;
    if (load_first || shift_en) begin
      if (dir_q == DIR_LSB_FIRST) word_next = {S_IN, base[ANCHO-1:1]};
      else                        word_next = {base[ANCHO-2:0], S_IN};
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) word <= '0;
    else       word <= word_next;
  end

endmodule

// File: rtl/deserializador_4_bits.sv
// Serial-to-parallel receiver: frame FSM, bit counter, double-buffered
// output slot with VALID/RDY_IN handshake and sticky OVERRUN.
module deserializador_4_bits
  import deserializador_4_bits_pkg::*;
#(
  parameter int ANCHO = ANCHO_DEF
) (
  input logic                     CLK,
  input logic                     RESET,
  deserializador_4_bits_if.slave  bus
);

  localparam int CW = $clog2(ANCHO + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(ANCHO - 1);

  logic [0:0]       state;
  logic [CW-1:0]    count;
  logic             dir_q;
  logic [ANCHO-1:0] q_reg;
  logic             valid;
  logic             overrun;

  logic             start_now;
  logic             shift_now;
  logic             complete;
  logic             dir_eff;
  logic [ANCHO-1:0] word_next;
  logic [ANCHO-1:0] word;

  // START with ENB always begins a new frame, discarding any partial one
  assign start_now = bus.ENB && bus.START;
  assign shift_now = bus.ENB && !bus.START && (state == ST_RECIBE);
  assign complete  = shift_now && (count == LAST_IDX);
  assign dir_eff   = start_now ? bus.DIR : dir_q;

  deserializador_4_bits_captura_serie #(.ANCHO(ANCHO)) u_captura (
    .CLK        (CLK),
    .RESET      (RESET),
    .shift_en   (shift_now),
    .load_first (start_now),
    .dir_q      (dir_eff),
    .S_IN       (bus.S_IN),
    .word_next  (word_next),
    .word       (word)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= ST_IDLE;
      count <= '0;
      dir_q <= DIR_MSB_FIRST;
    end else if (start_now) begin
      state <= ST_RECIBE;
      count <= CW'(1);
      dir_q <= bus.DIR;
    end else if (complete) begin
      state <= ST_IDLE;
      count <= '0;
    end else if (shift_now) begin
      count <= count + CW'(1);
    end
  end

  // A completing word is dropped only when the slot is full and not being consumed
  always_ff @(posedge CLK) begin
    if (RESET) begin
      q_reg   <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else if (complete) begin
      if (!valid || bus.RDY_IN) begin
        q_reg <= word_next;
        valid <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (valid && bus.RDY_IN) begin
      valid <= 1'b0;
    end
  end

  assign bus.Q         = q_reg;
  assign bus.VALID     = valid;
  assign bus.BUSY      = (state == ST_RECIBE);
  assign bus.OVERRUN   = overrun;
  assign bus.state_dbg = state;

endmodule
